// File: rtl/stack_pkg.sv
// Shared types and constants for the stack engine and its command sequencer.
// Upstream logic and benches use the opcode constants; the sequencer uses the state enum.
package stack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_e;

  localparam int          OP_W    = 4;
  localparam logic [3:0]  OP_PUSH = 4'd7;
  localparam logic [3:0]  OP_ALT  = 4'd5;

  // Counts up to 16'hFFFF and then holds there.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/stack_cmd_fifo.sv
// Command FIFO for the stack sequencer: DEPTH entries of {op,data}, wrap-bit pointers,
// registered ready (not full) and a look-ahead empty flag for the owner's status logic.
module stack_cmd_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         ready,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         empty_nx
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic [AW:0]  wr_nx, rd_nx;
  logic         do_push, do_pop, full_nx;

  assign do_push = push && ready;
  assign do_pop  = pop && !empty;

  // NOTE: always_comb gives every output a default first, so no path can infer a latch.
  always_comb begin
    wr_nx = wr_ptr;
    rd_nx = rd_ptr;
    if (do_push) wr_nx = wr_ptr + PTR_ONE;
    if (do_pop)  rd_nx = rd_ptr + PTR_ONE;
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign empty_nx = (wr_nx == rd_nx);
  assign full_nx  = (wr_nx[AW] != rd_nx[AW]) && (wr_nx[AW-1:0] == rd_nx[AW-1:0]);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ready  <= 1'b1;
    end else begin
      wr_ptr <= wr_nx;
      rd_ptr <= rd_nx;
      ready  <= !full_nx;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/stack_cmd_sequencer.sv
// Initiator-side driver for the stack engine: FIFO-queued commands, apply/valid issue with a
// WAIT timeout, and a valid/ready response channel. Define STACK_SEQ_STATS_EN for stat_done/stat_timeout.
module stack_cmd_sequencer
  import stack_pkg::*;
#(
  parameter int W       = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  output logic [3:0]   stk_op,
  output logic [W-1:0] stk_in,
  output logic         stk_apply,
  input  logic [W-1:0] stk_head,
  input  logic         stk_empty,
  input  logic         stk_valid,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_head,
  output logic         rsp_empty,
  output logic         rsp_err,
  output logic         busy
`ifdef STACK_SEQ_STATS_EN
  ,
  output logic [15:0]  stat_done,
  output logic [15:0]  stat_timeout
`endif
);

  localparam int         FW     = W + OP_W;
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  seq_state_e     state, state_nx;
  logic [7:0]     cnt, cnt_nx;
  logic           f_pop, f_empty, f_empty_nx;
  logic [FW-1:0]  f_rdata;
  logic [3:0]     op_nx;
  logic [W-1:0]   in_nx, rh_nx;
  logic           apply_nx, rv_nx, re_nx, rerr_nx, busy_nx;

  stack_cmd_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (cmd_valid),
    .pop      (f_pop),
    .wdata    ({cmd_op, cmd_data}),
    .ready    (cmd_ready),
    .rdata    (f_rdata),
    .empty    (f_empty),
    .empty_nx (f_empty_nx)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    f_pop    = 1'b0;
    op_nx    = stk_op;
    in_nx    = stk_in;
    apply_nx = stk_apply;
    rv_nx    = rsp_valid;
    rh_nx    = rsp_head;
    re_nx    = rsp_empty;
    rerr_nx  = rsp_err;
    case (state)
      IDLE: begin
        if (!f_empty) begin
          f_pop           = 1'b1;
          {op_nx, in_nx}  = f_rdata;
          apply_nx        = 1'b1;
          state_nx        = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        // A completion in the timeout cycle still counts as a good response.
        if (stk_valid) begin
          rh_nx    = stk_head;
          re_nx    = stk_empty;
          rerr_nx  = 1'b0;
          apply_nx = 1'b0;
          rv_nx    = 1'b1;
          state_nx = RESP;
        end else if (cnt == TO_CNT) begin
          rerr_nx  = 1'b1;
          apply_nx = 1'b0;
          rv_nx    = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rv_nx    = 1'b0;
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE) || !f_empty_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      stk_op    <= '0;
      stk_in    <= '0;
      stk_apply <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_head  <= '0;
      rsp_empty <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      stk_op    <= op_nx;
      stk_in    <= in_nx;
      stk_apply <= apply_nx;
      rsp_valid <= rv_nx;
      rsp_head  <= rh_nx;
      rsp_empty <= re_nx;
      rsp_err   <= rerr_nx;
      busy      <= busy_nx;
    end
  end

`ifdef STACK_SEQ_STATS_EN
  logic rsp_hs;
  assign rsp_hs = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_done    <= '0;
      stat_timeout <= '0;
    end else if (rsp_hs) begin
      if (rsp_err) stat_timeout <= sat_inc16(stat_timeout);
      else         stat_done    <= sat_inc16(stat_done);
    end
  end
`endif

endmodule
